// File: rtl/fetch_pair_unit_pkg.sv
// fetch_pkg: shared widths, fetch queue entry layout and fetch FSM states
package fetch_pkg;
    localparam int XLEN_DEF     = 64;
    localparam int INSTR_W      = 32;
    localparam int FETCH_STRIDE = 8;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [INSTR_W-1:0]  instr1;
        logic [INSTR_W-1:0]  instr2;
    } fetch_entry_t;

    typedef enum logic {RUN, FAULT} fetch_state_t;
endpackage

// File: rtl/fetch_pair_unit_queue.sv
// fetch_queue: DEPTH-entry circular FIFO of fetched pairs with single-cycle flush
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t data,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);
    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr;
    logic [AW-1:0]  rd;
    logic [AW:0]    count;

    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign head  = mem[rd];

    // Storage and pointers; DEPTH is a power of 2 so pointers wrap by overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr    <= '0;
            rd    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr    <= '0;
            rd    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wr] <= data;
                wr      <= wr + 1'b1;
            end
            if (pop) rd <= rd + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
endmodule

// File: rtl/fetch_pair_unit.sv
// fetch_pair_unit: 2-wide fetch stage with PC, fetch queue and redirect/fault FSM.
// Optional FETCH_PERF_CNT_EN adds saturating fetch and decode-stall counters.
module fetch_pair_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              QDEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               branch_en,
    input  logic [XLEN-1:0]    branch_pc,
    output logic [XLEN-1:0]    pc_o,
    output logic [XLEN-1:0]    pc4_o,
    input  logic [INSTR_W-1:0] instr1_i,
    input  logic [INSTR_W-1:0] instr2_i,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [XLEN-1:0]    dec_pc,
    output logic [INSTR_W-1:0] dec_instr1,
    output logic [INSTR_W-1:0] dec_instr2,
    output logic               fetch_fault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_stall_cnt
`endif
);
    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    fetch_entry_t    head;
    fetch_entry_t    entry;

    assign pc_o       = pc;
    assign pc4_o      = pc + XLEN'(4);
    assign dec_valid  = !empty && !branch_en;
    assign pop        = dec_valid && dec_ready;
    // A pop in the same cycle frees a slot, so a full queue still accepts a pair
    assign push       = state == RUN && !branch_en && (!full || pop);
    assign entry      = '{pc: XLEN_DEF'(pc), instr1: instr1_i, instr2: instr2_i};
    assign dec_pc     = XLEN'(head.pc);
    assign dec_instr1 = head.instr1;
    assign dec_instr2 = head.instr2;

    fetch_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (branch_en),
        .data  (entry),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    // PC and RUN/FAULT FSM; redirect wins, misaligned targets park fetch in FAULT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            pc          <= RESET_PC;
            fetch_fault <= 1'b0;
        end else if (branch_en) begin
            pc          <= branch_pc;
            state       <= branch_pc[1:0] != 2'b00 ? FAULT : RUN;
            fetch_fault <= branch_pc[1:0] != 2'b00;
        end else if (push) begin
            pc <= pc + XLEN'(FETCH_STRIDE);
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating counters of enqueued pairs and decode-stall cycles; redirect does not clear them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (push && perf_fetch_cnt != '1) perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
            if (dec_valid && !dec_ready && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_pair_unit.sv
// tb_fetch_pair_unit: directed table, hand sequences and random run against a queue-based model
module tb_fetch_pair_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        branch_en = 1'b0;
    logic [63:0] branch_pc = '0;
    logic [63:0] pc_o, pc4_o, dec_pc;
    logic [31:0] instr1_i, instr2_i, dec_instr1, dec_instr2;
    logic        dec_valid, dec_ready = 1'b0, fetch_fault;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [63:0] a);
        if (a == 64'h0) return 32'h015A04B3;
        if (a == 64'h4) return 32'h00148493;
        return (a[31:0] * 32'h9E3779B1) ^ 32'hA5A50F0F;
    endfunction

    assign instr1_i = imem(pc_o);
    assign instr2_i = imem(pc4_o);

    fetch_pair_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .branch_en   (branch_en),
        .branch_pc   (branch_pc),
        .pc_o        (pc_o),
        .pc4_o       (pc4_o),
        .instr1_i    (instr1_i),
        .instr2_i    (instr2_i),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_pc      (dec_pc),
        .dec_instr1  (dec_instr1),
        .dec_instr2  (dec_instr2),
        .fetch_fault (fetch_fault)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    // Reference model: list of PCs queued, current fetch PC, fault flag, perf counts
    logic [63:0] mq[$];
    logic [63:0] mpc;
    bit          mfault;
    int unsigned mpf, mps;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", n, a, e);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mpc = 64'h0;
        mfault = 1'b0;
        mpf = 0;
        mps = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        branch_en = 1'b0;
        branch_pc = '0;
        dec_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc_o, 64'h0);
        chk("rst_pc4", pc4_o, 64'h4);
        chk("rst_valid", 64'(dec_valid), 64'h0);
        chk("rst_fault", 64'(fetch_fault), 64'h0);
        rst_n = 1'b1;
    endtask

    // One clock: drive inputs, compare against model mid-cycle, then advance model at the edge
    task automatic cycle(input bit br, input logic [63:0] bpc, input bit rdy,
                         output bit sv, output logic [63:0] spc, output logic [63:0] spco, output bit sf);
        bit ev, popd, was_full;
        branch_en = br;
        branch_pc = bpc;
        dec_ready = rdy;
        ev = mq.size() != 0 && !br;
        @(negedge clk);
        sv = dec_valid;
        spc = dec_pc;
        spco = pc_o;
        sf = fetch_fault;
        chk("m_valid", 64'(dec_valid), 64'(ev));
        chk("m_pc", pc_o, mpc);
        chk("m_pc4", pc4_o, mpc + 64'd4);
        chk("m_fault", 64'(fetch_fault), 64'(mfault));
        if (ev) begin
            chk("m_dec_pc", dec_pc, mq[0]);
            chk("m_instr1", 64'(dec_instr1), 64'(imem(mq[0])));
            chk("m_instr2", 64'(dec_instr2), 64'(imem(mq[0] + 64'd4)));
        end
        @(posedge clk);
        if (br) begin
            mq.delete();
            mpc = bpc;
            mfault = bpc[1:0] != 2'b00;
        end else begin
            popd = ev && rdy;
            was_full = mq.size() == 4;
            if (ev && !rdy && mps != 32'hFFFFFFFF) mps++;
            if (popd) void'(mq.pop_front());
            if (!mfault && (!was_full || popd)) begin
                mq.push_back(mpc);
                mpc = mpc + 64'd8;
                if (mpf != 32'hFFFFFFFF) mpf++;
            end
        end
        #1;
    endtask

    typedef struct {
        bit          br;
        logic [63:0] bpc;
        bit          rdy;
        bit          ev;
        logic [63:0] epc;
        logic [63:0] epco;
        bit          ef;
    } vec_t;

    vec_t tbl[13];
    bit sv, sf;
    logic [63:0] spc, spco;
    logic [63:0] got[$];

    initial begin
        tbl[0]  = '{0, 64'h0,  1, 0, 64'h0,  64'h0,  0};
        tbl[1]  = '{0, 64'h0,  1, 1, 64'h0,  64'h8,  0};
        tbl[2]  = '{0, 64'h0,  1, 1, 64'h8,  64'h10, 0};
        tbl[3]  = '{0, 64'h0,  1, 1, 64'h10, 64'h18, 0};
        tbl[4]  = '{1, 64'h54, 1, 0, 64'h0,  64'h20, 0};
        tbl[5]  = '{0, 64'h0,  1, 0, 64'h0,  64'h54, 0};
        tbl[6]  = '{0, 64'h0,  1, 1, 64'h54, 64'h5C, 0};
        tbl[7]  = '{1, 64'h56, 1, 0, 64'h0,  64'h64, 0};
        tbl[8]  = '{0, 64'h0,  1, 0, 64'h0,  64'h56, 1};
        tbl[9]  = '{0, 64'h0,  1, 0, 64'h0,  64'h56, 1};
        tbl[10] = '{1, 64'h2C, 1, 0, 64'h0,  64'h56, 1};
        tbl[11] = '{0, 64'h0,  1, 0, 64'h0,  64'h2C, 0};
        tbl[12] = '{0, 64'h0,  1, 1, 64'h2C, 64'h34, 0};

        // Directed table: streaming from reset, redirect, misaligned fault and recovery
        do_reset();
        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].br, tbl[i].bpc, tbl[i].rdy, sv, spc, spco, sf);
            chk($sformatf("t%0d_valid", i), 64'(sv), 64'(tbl[i].ev));
            chk($sformatf("t%0d_pc_o", i), spco, tbl[i].epco);
            chk($sformatf("t%0d_fault", i), 64'(sf), 64'(tbl[i].ef));
            if (tbl[i].ev) chk($sformatf("t%0d_dec_pc", i), spc, tbl[i].epc);
        end

        // First pair carries the preloaded instructions at address 0
        do_reset();
        cycle(0, 0, 0, sv, spc, spco, sf);
        branch_en = 1'b0;
        #1;
        chk("pair0_instr1", 64'(dec_instr1), 64'h015A04B3);
        chk("pair0_instr2", 64'(dec_instr2), 64'h00148493);

        // Decode stall fills the queue and freezes PC; release drains in order
        do_reset();
        repeat (10) cycle(0, 0, 0, sv, spc, spco, sf);
        chk("stall_pc_frozen", pc_o, 64'h20);
        got.delete();
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 1, sv, spc, spco, sf);
            if (sv) got.push_back(spc);
        end
        chk("drain_n", 64'(got.size()), 64'd4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk($sformatf("drain_%0d", i), got[i], 64'(8 * i));

        // Redirect with 3 entries queued: stale pairs vanish, target appears 2 cycles later
        do_reset();
        repeat (3) cycle(0, 0, 0, sv, spc, spco, sf);
        cycle(1, 64'h54, 1, sv, spc, spco, sf);
        chk("redir_valid_same", 64'(sv), 64'h0);
        cycle(0, 0, 1, sv, spc, spco, sf);
        chk("redir_valid_next", 64'(sv), 64'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1, sv, spc, spco, sf);
            chk($sformatf("redir_seq_%0d", i), spc, 64'h54 + 64'(8 * i));
        end

        // Full queue with decode ready: one push and one pop per cycle, then async reset mid-stream
        do_reset();
        repeat (6) cycle(0, 0, 0, sv, spc, spco, sf);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 1, sv, spc, spco, sf);
            chk($sformatf("full_flow_gap_%0d", i), spco - spc, 64'h20);
        end
        branch_en = 1'b0;
        dec_ready = 1'b1;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pc", pc_o, 64'h0);
        chk("async_rst_valid", 64'(dec_valid), 64'h0);
        chk("async_rst_dec_pc", dec_pc, 64'h0);
        chk("async_rst_instr1", 64'(dec_instr1), 64'h0);
        chk("async_rst_instr2", 64'(dec_instr2), 64'h0);
        chk("async_rst_fault", 64'(fetch_fault), 64'h0);

`ifdef FETCH_PERF_CNT_EN
        do_reset();
        cycle(0, 0, 1, sv, spc, spco, sf);
        repeat (3) cycle(0, 0, 0, sv, spc, spco, sf);
        cycle(0, 0, 1, sv, spc, spco, sf);
        chk("perf_fetch", 64'(perf_fetch_cnt), 64'd5);
        chk("perf_stall", 64'(perf_stall_cnt), 64'd3);
        cycle(1, 64'h100, 0, sv, spc, spco, sf);
        chk("perf_fetch_kept", 64'(perf_fetch_cnt), 64'd5);
`endif

        // Random traffic including misaligned targets and PC wrap near all-ones
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit br;
            logic [63:0] bpc;
            br = $urandom_range(0, 99) < 6;
            bpc = $urandom_range(0, 9) == 0 ? 64'hFFFF_FFFF_FFFF_FFE0 : 64'($urandom_range(0, 1023));
            cycle(br, bpc, $urandom_range(0, 3) != 0, sv, spc, spco, sf);
        end
`ifdef FETCH_PERF_CNT_EN
        chk("rand_perf_fetch", 64'(perf_fetch_cnt), 64'(mpf));
        chk("rand_perf_stall", 64'(perf_stall_cnt), 64'(mps));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
